mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares one single-ported memory between an instruction-fetch port (p_*)
// and a load/store port (d_*). Each transaction runs through a small FSM:
//
//   IDLE   -> ACCESS  a request is sampled; the winner's address, write
//                     enable and write data are latched on that edge
//   ACCESS -> RESP    after exactly MEM_LAT cycles with CS asserted; read
//                     data is captured on the edge that ends the last cycle
//   RESP   -> IDLE    the winner's ack is high for this one cycle
//
// A request sampled at edge k gives CS in cycles k+1..k+MEM_LAT and the ack
// in cycle k+MEM_LAT+1. Back-to-back throughput is one transaction every
// MEM_LAT+2 cycles.
//
// Compile-time option:
//   ARB_RR_EN  defined   : simultaneous requests alternate round-robin. The
//                          pointer moves to the other port after every
//                          completed grant and favours the data port out
//                          of reset.
//              undefined : the data port always wins a tie. A continuously
//                          asserted d_req starves the fetch port.
//
// Parameters:
//   MEM_LAT  memory access cycles per transaction (1..15)
//   DW       address / data width
//
// Ports:
//   CLK             system clock, rising edge
//   reset           synchronous active-high reset
//   p_req           fetch request
//   p_addr          fetch address
//   p_ack           one-cycle fetch completion pulse
//   p_rdata         last fetched word, held until the next fetch completes
//   d_req           data request
//   d_we            1 = store, 0 = load
//   d_addr          data address
//   d_wdata         store data
//   d_ack           one-cycle data completion pulse
//   d_rdata         last loaded word, held until the next load completes
//   ADDR            memory address (valid only while CS is high)
//   Data_BUS_WRITE  memory write data (non-zero only during a store access)
//   Data_BUS_READ   memory read data
//   CS              memory chip select, high for the ACCESS cycles
//   WE              memory write enable, high for the ACCESS cycles of a store
//   busy            high whenever the FSM is not in IDLE
//   grant_d         high while the data port owns the bus (ACCESS and RESP)
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int MEM_LAT = 2,
    parameter int DW      = 32
) (
    input  logic          CLK,
    input  logic          reset,

    input  logic          p_req,
    input  logic [DW-1:0] p_addr,
    output logic          p_ack,
    output logic [DW-1:0] p_rdata,

    input  logic          d_req,
    input  logic          d_we,
    input  logic [DW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,

    output logic [DW-1:0] ADDR,
    output logic [DW-1:0] Data_BUS_WRITE,
    input  logic [DW-1:0] Data_BUS_READ,
    output logic          CS,
    output logic          WE,

    output logic          busy,
    output logic          grant_d
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Counter value seen in the final ACCESS cycle. Four bits cover the
    // whole 1..15 latency range.
    localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

    state_t        state_reg;
    logic [3:0]    cnt_reg;

    // Transaction registers. They are loaded when a winner is chosen and
    // cleared when the access phase ends, so they drive the memory bus
    // directly and read zero outside ACCESS.
    logic [DW-1:0] addr_reg;
    logic [DW-1:0] wdata_reg;
    logic          we_reg;
    logic          cs_reg;

    // Owner of the current transaction; stays valid through RESP so the
    // right ack fires and grant_d covers the whole ownership window.
    logic          sel_d_reg;

    logic          busy_reg;
    logic          p_ack_reg;
    logic          d_ack_reg;
    logic [DW-1:0] p_rdata_reg;
    logic [DW-1:0] d_rdata_reg;

    logic          win_d;

`ifdef ARB_RR_EN
    // 1 = data port wins the next tie, 0 = fetch port wins it.
    logic          rr_reg;

    always_comb begin
        win_d = d_req;
        if (d_req && p_req) begin
            win_d = rr_reg;
        end
    end
`else
    // Fixed priority: the data port wins whenever it asks.
    always_comb begin
        win_d = d_req;
    end
`endif

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            we_reg      <= 1'b0;
            cs_reg      <= 1'b0;
            sel_d_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            p_ack_reg   <= 1'b0;
            d_ack_reg   <= 1'b0;
            p_rdata_reg <= '0;
            d_rdata_reg <= '0;
`ifdef ARB_RR_EN
            rr_reg      <= 1'b1;
`endif
        end else begin
            // Acks are single-cycle pulses; only the ACCESS->RESP
            // transition raises one.
            p_ack_reg <= 1'b0;
            d_ack_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (p_req || d_req) begin
                        state_reg <= ACCESS;
                        cnt_reg   <= '0;
                        cs_reg    <= 1'b1;
                        busy_reg  <= 1'b1;
                        sel_d_reg <= win_d;
                        addr_reg  <= win_d ? d_addr : p_addr;
                        we_reg    <= win_d & d_we;
                        // Reads keep the write bus at zero.
                        wdata_reg <= (win_d && d_we) ? d_wdata : '0;
                    end
                end

                ACCESS: begin
                    if (cnt_reg == LAST_CNT) begin
                        state_reg <= RESP;
                        cs_reg    <= 1'b0;
                        we_reg    <= 1'b0;
                        addr_reg  <= '0;
                        wdata_reg <= '0;
                        // Read data is valid on the last access cycle.
                        // A store leaves d_rdata untouched.
                        if (sel_d_reg) begin
                            d_ack_reg <= 1'b1;
                            if (!we_reg) begin
                                d_rdata_reg <= Data_BUS_READ;
                            end
                        end else begin
                            p_ack_reg   <= 1'b1;
                            p_rdata_reg <= Data_BUS_READ;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 4'd1;
                    end
                end

                RESP: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                    busy_reg  <= 1'b0;
                    sel_d_reg <= 1'b0;
`ifdef ARB_RR_EN
                    // Next tie goes to whichever port was not just served.
                    rr_reg    <= ~sel_d_reg;
`endif
                end

                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                    cs_reg    <= 1'b0;
                    we_reg    <= 1'b0;
                    addr_reg  <= '0;
                    wdata_reg <= '0;
                    busy_reg  <= 1'b0;
                    sel_d_reg <= 1'b0;
                end
            endcase
        end
    end

    assign ADDR           = addr_reg;
    assign Data_BUS_WRITE = wdata_reg;
    assign CS             = cs_reg;
    assign WE             = we_reg;
    assign busy           = busy_reg;
    assign grant_d        = sel_d_reg;
    assign p_ack          = p_ack_reg;
    assign d_ack          = d_ack_reg;
    assign p_rdata        = p_rdata_reg;
    assign d_rdata        = d_rdata_reg;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Directed bench for mem_bus_arbiter at MEM_LAT=2, DW=32. The stimulus
// process pushes the expected completion (owning port and rdata) into a
// scoreboard queue as each request is issued; a monitor on the falling edge
// pops an entry whenever an ack appears and compares it. The stimulus
// process also checks bus-level timing (CS/ADDR/WE/Data_BUS_WRITE) cycle by
// cycle. Works with or without ARB_RR_EN defined.
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    localparam int DW = 32;

    logic          CLK = 1'b0;
    logic          reset;
    logic          p_req;
    logic [DW-1:0] p_addr;
    logic          p_ack;
    logic [DW-1:0] p_rdata;
    logic          d_req;
    logic          d_we;
    logic [DW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic [DW-1:0] ADDR;
    logic [DW-1:0] Data_BUS_WRITE;
    logic [DW-1:0] Data_BUS_READ;
    logic          CS;
    logic          WE;
    logic          busy;
    logic          grant_d;

    always #5 CLK = ~CLK;

    mem_bus_arbiter #(
        .MEM_LAT (2),
        .DW      (DW)
    ) dut (
        .CLK            (CLK),
        .reset          (reset),
        .p_req          (p_req),
        .p_addr         (p_addr),
        .p_ack          (p_ack),
        .p_rdata        (p_rdata),
        .d_req          (d_req),
        .d_we           (d_we),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .d_ack          (d_ack),
        .d_rdata        (d_rdata),
        .ADDR           (ADDR),
        .Data_BUS_WRITE (Data_BUS_WRITE),
        .Data_BUS_READ  (Data_BUS_READ),
        .CS             (CS),
        .WE             (WE),
        .busy           (busy),
        .grant_d        (grant_d)
    );

    typedef struct packed {
        logic        is_d;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb_q[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   txn_count  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_p_ack"},   32'(p_ack),   32'd0);
        chk({tag, "_d_ack"},   32'(d_ack),   32'd0);
        chk({tag, "_CS"},      32'(CS),      32'd0);
        chk({tag, "_WE"},      32'(WE),      32'd0);
        chk({tag, "_busy"},    32'(busy),    32'd0);
        chk({tag, "_grant_d"}, 32'(grant_d), 32'd0);
        chk({tag, "_ADDR"},    ADDR,           32'd0);
        chk({tag, "_DBW"},     Data_BUS_WRITE, 32'd0);
        chk({tag, "_p_rdata"}, p_rdata,        32'd0);
        chk({tag, "_d_rdata"}, d_rdata,        32'd0);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: every ack must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        exp_t e;
        if (p_ack || d_ack) begin
            if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_ack: got p_ack=%b d_ack=%b, expected no ack", p_ack, d_ack);
            end else begin
                e = sb_q.pop_front();
                txn_count++;
                $display("txn %0d: %s ack, p_rdata=%h d_rdata=%h (expected %s rdata %h)",
                         txn_count, d_ack ? "data" : "fetch", p_rdata, d_rdata,
                         e.is_d ? "data" : "fetch", e.rdata);
                chk("ack_d",       32'(d_ack),   32'(e.is_d));
                chk("ack_p",       32'(p_ack),   32'(!e.is_d));
                chk("ack_grant_d", 32'(grant_d), 32'(e.is_d));
                chk("ack_cs_low",  32'(CS),      32'd0);
                chk("ack_rdata",   e.is_d ? d_rdata : p_rdata, e.rdata);
            end
        end
    end

    initial begin
        exp_t e;
        logic exp_d;

        reset         = 1'b1;
        p_req         = 1'b0;
        p_addr        = '0;
        d_req         = 1'b0;
        d_we          = 1'b0;
        d_addr        = '0;
        d_wdata       = '0;
        Data_BUS_READ = '0;

        tick();
        tick();
        chk_all_zero("rst");
        reset = 1'b0;
        tick();

        // ---- Fetch only -------------------------------------------------
        p_req = 1'b1; p_addr = 32'h40; Data_BUS_READ = 32'h064F;
        e.is_d = 1'b0; e.rdata = 32'h064F; sb_q.push_back(e);
        tick();                                  // ACCESS 1
        p_req = 1'b0;
        chk("f_cs1",   32'(CS),      32'd1);
        chk("f_addr1", ADDR,         32'h40);
        chk("f_we1",   32'(WE),      32'd0);
        chk("f_busy1", 32'(busy),    32'd1);
        chk("f_gnt1",  32'(grant_d), 32'd0);
        tick();                                  // ACCESS 2
        chk("f_cs2",   32'(CS),      32'd1);
        chk("f_addr2", ADDR,         32'h40);
        chk("f_ack2",  32'(p_ack),   32'd0);
        tick();                                  // RESP
        chk("f_cs3",   32'(CS),      32'd0);
        chk("f_ack3",  32'(p_ack),   32'd1);
        tick();                                  // IDLE
        chk("f_ack4",  32'(p_ack),   32'd0);
        chk("f_busy4", 32'(busy),    32'd0);
        chk("f_rdata", p_rdata,      32'h064F);

        // ---- Store ------------------------------------------------------
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'h22B4;
        Data_BUS_READ = 32'hDEAD_BEEF;
        e.is_d = 1'b1; e.rdata = 32'h0; sb_q.push_back(e);
        tick();
        // Inputs become don't-care once latched.
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'hFFFF_FFFF;
        chk("s_we1",   32'(WE),      32'd1);
        chk("s_dbw1",  Data_BUS_WRITE, 32'h22B4);
        chk("s_addr1", ADDR,         32'h100);
        chk("s_gnt1",  32'(grant_d), 32'd1);
        tick();
        chk("s_we2",   32'(WE),      32'd1);
        chk("s_dbw2",  Data_BUS_WRITE, 32'h22B4);
        tick();
        chk("s_we3",   32'(WE),      32'd0);
        chk("s_dbw3",  Data_BUS_WRITE, 32'h0);
        chk("s_ack3",  32'(d_ack),   32'd1);
        tick();
        chk("s_ack4",  32'(d_ack),   32'd0);
        chk("s_rdata", d_rdata,      32'h0);

        // ---- Load -------------------------------------------------------
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; Data_BUS_READ = 32'hA5A5_A5A5;
        e.is_d = 1'b1; e.rdata = 32'hA5A5_A5A5; sb_q.push_back(e);
        tick();
        d_req = 1'b0;
        chk("l_we1",   32'(WE),      32'd0);
        chk("l_dbw1",  Data_BUS_WRITE, 32'h0);
        chk("l_addr1", ADDR,         32'h200);
        tick();
        tick();
        tick();
        chk("l_rdata",      d_rdata, 32'hA5A5_A5A5);
        chk("l_p_rdata_hold", p_rdata, 32'h064F);

        // ---- Reset so the arbitration pointer starts from its reset value
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst2_d_rdata", d_rdata, 32'h0);
        chk("rst2_p_rdata", p_rdata, 32'h0);

        // ---- Both ports requesting for four transactions ----------------
        p_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        p_addr = 32'h300; d_addr = 32'h400;
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_RR_EN
            exp_d = (i % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            Data_BUS_READ = 32'h1000 + 32'(i);
            e.is_d = exp_d; e.rdata = 32'h1000 + 32'(i); sb_q.push_back(e);
            tick();
            chk("both_grant_d", 32'(grant_d), 32'(exp_d));
            chk("both_addr",    ADDR, exp_d ? 32'h400 : 32'h300);
            tick();
            tick();
            tick();
            chk("both_idle_busy", 32'(busy), 32'd0);
        end
        p_req = 1'b0; d_req = 1'b0;
        tick();

        // ---- Reset during the first ACCESS cycle of a fetch -------------
        p_req = 1'b1; p_addr = 32'h80; Data_BUS_READ = 32'h5555;
        tick();
        chk("ra_cs_before", 32'(CS), 32'd1);
        reset = 1'b1; p_req = 1'b0;
        tick();
        reset = 1'b0;
        chk_all_zero("ra");
        tick();
        chk("ra_no_ack1", 32'(p_ack), 32'd0);
        tick();
        chk("ra_no_ack2", 32'(p_ack), 32'd0);
        tick();

        // ---- Fetch request dropped during ACCESS ------------------------
        p_req = 1'b1; p_addr = 32'hC0; Data_BUS_READ = 32'h1234;
        e.is_d = 1'b0; e.rdata = 32'h1234; sb_q.push_back(e);
        tick();                                  // ACCESS 1
        chk("dr_cs1", 32'(CS), 32'd1);
        p_req = 1'b0;
        tick();                                  // ACCESS 2
        chk("dr_cs2",   32'(CS), 32'd1);
        chk("dr_addr2", ADDR,    32'hC0);
        tick();                                  // RESP
        chk("dr_ack",   32'(p_ack), 32'd1);
        tick();
        chk("dr_rdata", p_rdata, 32'h1234);
        chk("dr_busy",  32'(busy), 32'd0);

        // ---- Every expected completion must have been observed ----------
        tick();
        tick();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
